// File: rtl/ob_pkg.sv
// Shared types for the order-book match engine: command opcodes, response
// status codes, controller states and the width-independent part of the
// registered compare result.
package ob_pkg;

  typedef enum logic [2:0] {
    OpNop  = 3'd0,
    OpBuy  = 3'd1,
    OpSell = 3'd2,
    OpQry  = 3'd3
  } opcode_e;

  typedef enum logic [1:0] {
    StsOkay   = 2'd0,
    StsTrade  = 2'd1,
    StsReject = 2'd2,
    StsBadop  = 2'd3
  } rsp_sts_e;

  typedef enum logic [2:0] {
    IDLE,
    DEC,
    WAIT,
    CMP,
    EXE
  } fsm_state_t;

  // Width-free compare flags; the engine wraps them with its own QTY_W fields.
  typedef struct packed {
    logic can;     // heads cross
    logic bid_gt;  // bid qty strictly larger
    logic ask_gt;  // ask qty strictly larger
  } cmp_flags_t;

  // True for opcodes that install an order into a table.
  function automatic logic is_order(input logic [2:0] opc);
    return (opc == OpBuy) || (opc == OpSell);
  endfunction

endpackage

// File: rtl/ob_rsp_skid.sv
// One-entry ready/valid response register.
// Ports:
//   clk, rst          clock, async active-high reset
//   in_vld/in_rdy     upstream handshake; in_rdy when empty or draining
//   in_data [DW]      payload captured on in_vld & in_rdy
//   out_vld/out_rdy   downstream handshake
//   out_data [DW]     held stable while out_vld & ~out_rdy
module ob_rsp_skid #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [DW-1:0] in_data,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_data
);

  assign in_rdy = ~out_vld | out_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
    end else if (in_vld && in_rdy) begin
      out_vld  <= 1'b1;
      out_data <= in_data;
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/ob_match_engine.sv
// Order-book controller: decodes NOP/BUY/SELL/QRY, installs orders into the
// bid/ask head tables and runs head-of-book matching (at most MATCH_LIMIT
// trades per command), reporting through a ready/valid response slot.
// Ports:
//   cmd_*        command channel (vld/rdy, opc, uid, price, qty)
//   rsp_*        response channel (vld/rdy, sts, uid, bid_uid, ask_uid, price, qty)
//   bid_*/ask_*  head entry in, full in, insert/pop/upd pulses out
//   ins_*        shared insert payload; upd_qty new head quantity
// Optional: define OB_MATCH_ENGINE_STATS_EN to add saturating stat_trades,
// stat_volume and stat_rejects outputs.
module ob_match_engine
  import ob_pkg::*;
#(
  parameter int unsigned UID_W       = 8,
  parameter int unsigned PRICE_W     = 16,
  parameter int unsigned QTY_W       = 16,
  parameter int unsigned MATCH_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_vld,
  input  logic [2:0]         cmd_opc,
  input  logic [UID_W-1:0]   cmd_uid,
  input  logic [PRICE_W-1:0] cmd_price,
  input  logic [QTY_W-1:0]   cmd_qty,
  output logic               cmd_rdy,
  output logic               rsp_vld,
  input  logic               rsp_rdy,
  output logic [1:0]         rsp_sts,
  output logic [UID_W-1:0]   rsp_uid,
  output logic [UID_W-1:0]   rsp_bid_uid,
  output logic [UID_W-1:0]   rsp_ask_uid,
  output logic [PRICE_W-1:0] rsp_price,
  output logic [QTY_W-1:0]   rsp_qty,
`ifdef OB_MATCH_ENGINE_STATS_EN
  output logic [31:0]        stat_trades,
  output logic [31:0]        stat_volume,
  output logic [15:0]        stat_rejects,
`endif
  input  logic               bid_head_vld,
  input  logic [UID_W-1:0]   bid_head_uid,
  input  logic [PRICE_W-1:0] bid_head_price,
  input  logic [QTY_W-1:0]   bid_head_qty,
  input  logic               bid_full,
  input  logic               ask_head_vld,
  input  logic [UID_W-1:0]   ask_head_uid,
  input  logic [PRICE_W-1:0] ask_head_price,
  input  logic [QTY_W-1:0]   ask_head_qty,
  input  logic               ask_full,
  output logic               bid_insert,
  output logic               ask_insert,
  output logic [UID_W-1:0]   ins_uid,
  output logic [PRICE_W-1:0] ins_price,
  output logic [QTY_W-1:0]   ins_qty,
  output logic               bid_pop,
  output logic               ask_pop,
  output logic               bid_upd,
  output logic               ask_upd,
  output logic [QTY_W-1:0]   upd_qty
);

  localparam int unsigned CNT_W = $clog2(MATCH_LIMIT + 1);

  typedef struct packed {
    logic [2:0]         opc;
    logic [UID_W-1:0]   uid;
    logic [PRICE_W-1:0] price;
    logic [QTY_W-1:0]   qty;
  } cmd_t;

  typedef struct packed {
    cmp_flags_t       f;
    logic [QTY_W-1:0] tq;
    logic [QTY_W-1:0] rem;
  } cmp_result_t;

  typedef struct packed {
    logic [1:0]         sts;
    logic [UID_W-1:0]   uid;
    logic [UID_W-1:0]   bid_uid;
    logic [UID_W-1:0]   ask_uid;
    logic [PRICE_W-1:0] price;
    logic [QTY_W-1:0]   qty;
  } rsp_t;

  fsm_state_t       state_q;
  cmd_t             cmd_q;
  cmp_result_t      cmp_q, cmp_d;
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic             init_q;

  logic slot_free, push;
  rsp_t push_data, rsp_q;
  logic dec_full, dec_rsp;

  // Held low through reset and for the first edge after release.
  assign cmd_rdy = init_q & (state_q == IDLE) & ~rsp_vld;

  assign ins_uid   = cmd_q.uid;
  assign ins_price = cmd_q.price;
  assign ins_qty   = cmd_q.qty;

  assign dec_full = (cmd_q.opc == OpBuy) ? bid_full : ask_full;
  // Orders that will be installed produce no response in DEC.
  assign dec_rsp  = ~is_order(cmd_q.opc) | dec_full | (cmd_q.qty == '0);
  assign cnt_inc  = cnt_q + CNT_W'(1);

  always_comb begin
    cmp_d          = '0;
    cmp_d.f.can    = bid_head_vld & ask_head_vld & (bid_head_price >= ask_head_price);
    cmp_d.f.bid_gt = bid_head_qty > ask_head_qty;
    cmp_d.f.ask_gt = bid_head_qty < ask_head_qty;
    cmp_d.tq       = cmp_d.f.bid_gt ? ask_head_qty : bid_head_qty;
    cmp_d.rem      = cmp_d.f.bid_gt ? (bid_head_qty - ask_head_qty)
                                    : (ask_head_qty - bid_head_qty);
  end

  // Response generation; the FSM below takes the same slot_free decisions.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    unique case (state_q)
      DEC: begin
        if (dec_rsp && slot_free) begin
          push          = 1'b1;
          push_data.uid = cmd_q.uid;
          if (is_order(cmd_q.opc)) begin
            push_data.sts = StsReject;
          end else if (cmd_q.opc == OpNop) begin
            push_data.sts = StsOkay;
          end else if (cmd_q.opc == OpQry) begin
            push_data.sts   = StsOkay;
            push_data.price = bid_head_vld ? bid_head_price : '0;
            push_data.qty   = ask_head_vld ? QTY_W'(ask_head_price) : '0;
          end else begin
            push_data.sts = StsBadop;
          end
        end
      end
      EXE: begin
        if (cmp_q.f.can && slot_free) begin
          push              = 1'b1;
          push_data.sts     = StsTrade;
          push_data.uid     = '1;
          push_data.bid_uid = bid_head_uid;
          push_data.ask_uid = ask_head_uid;
          push_data.price   = ask_head_price;
          push_data.qty     = cmp_q.tq;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      cmp_q      <= '0;
      cnt_q      <= '0;
      init_q     <= 1'b0;
      bid_insert <= 1'b0;
      ask_insert <= 1'b0;
      bid_pop    <= 1'b0;
      ask_pop    <= 1'b0;
      bid_upd    <= 1'b0;
      ask_upd    <= 1'b0;
      upd_qty    <= '0;
    end else begin
      init_q     <= 1'b1;
      bid_insert <= 1'b0;
      ask_insert <= 1'b0;
      bid_pop    <= 1'b0;
      ask_pop    <= 1'b0;
      bid_upd    <= 1'b0;
      ask_upd    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmd_vld && cmd_rdy) begin
            cmd_q.opc   <= cmd_opc;
            cmd_q.uid   <= cmd_uid;
            cmd_q.price <= cmd_price;
            cmd_q.qty   <= cmd_qty;
            cnt_q       <= '0;
            state_q     <= DEC;
          end
        end
        DEC: begin
          if (dec_rsp) begin
            if (slot_free) state_q <= IDLE;
          end else begin
            bid_insert <= (cmd_q.opc == OpBuy);
            ask_insert <= (cmd_q.opc == OpSell);
            state_q    <= WAIT;
          end
        end
        WAIT: state_q <= CMP;
        CMP: begin
          cmp_q   <= cmp_d;
          state_q <= EXE;
        end
        EXE: begin
          if (!cmp_q.f.can) begin
            state_q <= IDLE;
          end else if (slot_free) begin
            // Pops/updates land in the same cycle the TRADE becomes visible.
            if (cmp_q.f.bid_gt) begin
              ask_pop <= 1'b1;
              bid_upd <= 1'b1;
              upd_qty <= cmp_q.rem;
            end else if (cmp_q.f.ask_gt) begin
              bid_pop <= 1'b1;
              ask_upd <= 1'b1;
              upd_qty <= cmp_q.rem;
            end else begin
              bid_pop <= 1'b1;
              ask_pop <= 1'b1;
            end
            if (cnt_inc == CNT_W'(MATCH_LIMIT)) begin
              cnt_q   <= '0;
              state_q <= IDLE;
            end else begin
              cnt_q   <= cnt_inc;
              state_q <= WAIT;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  ob_rsp_skid #(
    .DW($bits(rsp_t))
  ) u_rsp_skid (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (push),
    .in_rdy  (slot_free),
    .in_data (push_data),
    .out_vld (rsp_vld),
    .out_rdy (rsp_rdy),
    .out_data(rsp_q)
  );

  assign rsp_sts     = rsp_q.sts;
  assign rsp_uid     = rsp_q.uid;
  assign rsp_bid_uid = rsp_q.bid_uid;
  assign rsp_ask_uid = rsp_q.ask_uid;
  assign rsp_price   = rsp_q.price;
  assign rsp_qty     = rsp_q.qty;

`ifdef OB_MATCH_ENGINE_STATS_EN
  logic [32:0] vol_sum;
  assign vol_sum = {1'b0, stat_volume} + 33'(push_data.qty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_trades  <= '0;
      stat_volume  <= '0;
      stat_rejects <= '0;
    end else if (push) begin
      if (push_data.sts == StsTrade) begin
        if (!(&stat_trades)) stat_trades <= stat_trades + 32'd1;
        stat_volume <= vol_sum[32] ? '1 : vol_sum[31:0];
      end
      if (push_data.sts == StsReject && !(&stat_rejects)) begin
        stat_rejects <= stat_rejects + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ob_match_engine.sv
// Directed bench for ob_match_engine (MATCH_LIMIT = 2) with a small
// behavioural bid/ask table and a response log.
module tb_ob_match_engine;

  typedef struct packed {
    logic [7:0]  uid;
    logic [15:0] price;
    logic [15:0] qty;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_vld, cmd_rdy, rsp_vld, rsp_rdy;
  logic [2:0]  cmd_opc;
  logic [7:0]  cmd_uid, rsp_uid, rsp_bid_uid, rsp_ask_uid, ins_uid;
  logic [15:0] cmd_price, cmd_qty, rsp_price, rsp_qty, ins_price, ins_qty, upd_qty;
  logic [1:0]  rsp_sts;
  logic        bid_full, ask_full;
  logic        bid_insert, ask_insert, bid_pop, ask_pop, bid_upd, ask_upd;
  logic        bid_head_vld, ask_head_vld;
`ifdef OB_MATCH_ENGINE_STATS_EN
  logic [31:0] stat_trades, stat_volume;
  logic [15:0] stat_rejects;
`endif

  ent_t bid_mem [4] = '{default: '0};
  ent_t ask_mem [4] = '{default: '0};
  int   bid_n = 0, ask_n = 0;
  logic pre_bid, pre_ask, tb_clr;
  ent_t pre_ent;

  int   bid_ins_c = 0, ask_ins_c = 0, bid_pop_c = 0, ask_pop_c = 0;
  int   bid_upd_c = 0, ask_upd_c = 0;
  logic [15:0] last_upd = '0;
  ent_t last_ins = '0;

  logic [57:0] rsp_log [16];
  int   rsp_n = 0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign bid_head_vld = (bid_n > 0);
  assign ask_head_vld = (ask_n > 0);

  ob_match_engine #(
    .UID_W      (8),
    .PRICE_W    (16),
    .QTY_W      (16),
    .MATCH_LIMIT(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_vld       (cmd_vld),
    .cmd_opc       (cmd_opc),
    .cmd_uid       (cmd_uid),
    .cmd_price     (cmd_price),
    .cmd_qty       (cmd_qty),
    .cmd_rdy       (cmd_rdy),
    .rsp_vld       (rsp_vld),
    .rsp_rdy       (rsp_rdy),
    .rsp_sts       (rsp_sts),
    .rsp_uid       (rsp_uid),
    .rsp_bid_uid   (rsp_bid_uid),
    .rsp_ask_uid   (rsp_ask_uid),
    .rsp_price     (rsp_price),
    .rsp_qty       (rsp_qty),
`ifdef OB_MATCH_ENGINE_STATS_EN
    .stat_trades   (stat_trades),
    .stat_volume   (stat_volume),
    .stat_rejects  (stat_rejects),
`endif
    .bid_head_vld  (bid_head_vld),
    .bid_head_uid  (bid_mem[0].uid),
    .bid_head_price(bid_mem[0].price),
    .bid_head_qty  (bid_mem[0].qty),
    .bid_full      (bid_full),
    .ask_head_vld  (ask_head_vld),
    .ask_head_uid  (ask_mem[0].uid),
    .ask_head_price(ask_mem[0].price),
    .ask_head_qty  (ask_mem[0].qty),
    .ask_full      (ask_full),
    .bid_insert    (bid_insert),
    .ask_insert    (ask_insert),
    .ins_uid       (ins_uid),
    .ins_price     (ins_price),
    .ins_qty       (ins_qty),
    .bid_pop       (bid_pop),
    .ask_pop       (ask_pop),
    .bid_upd       (bid_upd),
    .ask_upd       (ask_upd),
    .upd_qty       (upd_qty)
  );

  // Behavioural FIFO tables plus event counters.
  always @(posedge clk) begin
    if (tb_clr) begin
      bid_n <= 0;
      ask_n <= 0;
    end else begin
      if (bid_pop) begin
        for (int i = 0; i < 3; i++) bid_mem[i] <= bid_mem[i+1];
        bid_n <= bid_n - 1;
      end else if (pre_bid) begin
        bid_mem[bid_n] <= pre_ent;
        bid_n <= bid_n + 1;
      end else if (bid_insert) begin
        bid_mem[bid_n] <= '{ins_uid, ins_price, ins_qty};
        bid_n <= bid_n + 1;
      end
      if (bid_upd) bid_mem[0].qty <= upd_qty;
      if (ask_pop) begin
        for (int i = 0; i < 3; i++) ask_mem[i] <= ask_mem[i+1];
        ask_n <= ask_n - 1;
      end else if (pre_ask) begin
        ask_mem[ask_n] <= pre_ent;
        ask_n <= ask_n + 1;
      end else if (ask_insert) begin
        ask_mem[ask_n] <= '{ins_uid, ins_price, ins_qty};
        ask_n <= ask_n + 1;
      end
      if (ask_upd) ask_mem[0].qty <= upd_qty;
    end
    if (bid_insert) bid_ins_c <= bid_ins_c + 1;
    if (ask_insert) ask_ins_c <= ask_ins_c + 1;
    if (bid_insert || ask_insert) last_ins <= '{ins_uid, ins_price, ins_qty};
    if (bid_pop) bid_pop_c <= bid_pop_c + 1;
    if (ask_pop) ask_pop_c <= ask_pop_c + 1;
    if (bid_upd) bid_upd_c <= bid_upd_c + 1;
    if (ask_upd) ask_upd_c <= ask_upd_c + 1;
    if (bid_upd || ask_upd) last_upd <= upd_qty;
    if (rsp_vld && rsp_rdy && rsp_n < 16) begin
      rsp_log[rsp_n] <= {rsp_sts, rsp_uid, rsp_bid_uid, rsp_ask_uid, rsp_price, rsp_qty};
      rsp_n <= rsp_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] o, input logic [7:0] u, input logic [15:0] p,
                      input logic [15:0] q);
    int t;
    t = 0;
    cmd_vld = 1'b1; cmd_opc = o; cmd_uid = u; cmd_price = p; cmd_qty = q;
    while (!cmd_rdy && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("send_rdy", {63'd0, cmd_rdy}, 64'd1);
    @(negedge clk);
    cmd_vld = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (!cmd_rdy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk(tag, {63'd0, cmd_rdy}, 64'd1);
  endtask

  task automatic preload(input logic to_bid, input ent_t e);
    pre_ent = e;
    pre_bid = to_bid;
    pre_ask = ~to_bid;
    @(negedge clk);
    pre_bid = 1'b0;
    pre_ask = 1'b0;
  endtask

  task automatic clr_tables();
    tb_clr = 1'b1;
    @(negedge clk);
    tb_clr = 1'b0;
  endtask

  initial begin
    int base, c0, c1, c2, c3;
    cmd_vld = 1'b0; cmd_opc = '0; cmd_uid = '0; cmd_price = '0; cmd_qty = '0;
    rsp_rdy = 1'b1; bid_full = 1'b0; ask_full = 1'b0;
    pre_bid = 1'b0; pre_ask = 1'b0; tb_clr = 1'b0; pre_ent = '0;

    // Reset state
    #2;
    chk("rst_ctl", {56'd0, cmd_rdy, rsp_vld, bid_insert, ask_insert, bid_pop, ask_pop,
                    bid_upd, ask_upd}, 64'd0);
    chk("rst_data", {rsp_sts, rsp_uid, rsp_price, rsp_qty, upd_qty}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", {63'd0, cmd_rdy}, 64'd1);

    // NOP with backpressure: response held, no new command accepted
    rsp_rdy = 1'b0;
    send(3'd0, 8'd5, 16'd0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("nop_hold", {rsp_vld, rsp_sts, rsp_uid, cmd_rdy}, {1'b1, 2'd0, 8'd5, 1'b0});
    end
    rsp_rdy = 1'b1;
    @(negedge clk);
    chk("nop_drain", {rsp_vld, cmd_rdy}, {1'b0, 1'b1});

    // BUY crosses a larger ask: partial fill of the ask
    preload(1'b0, '{8'd2, 16'd100, 16'd10});
    base = rsp_n; c0 = bid_ins_c; c1 = ask_upd_c; c2 = bid_pop_c; c3 = ask_pop_c;
    send(3'd1, 8'd3, 16'd101, 16'd4);
    wait_idle("trade_idle");
    chk("trade_n", rsp_n - base, 1);
    chk("trade_rsp", rsp_log[base], {2'd1, 8'hff, 8'd3, 8'd2, 16'd100, 16'd4});
    chk("trade_ins", bid_ins_c - c0, 1);
    chk("trade_ins_ent", last_ins, {8'd3, 16'd101, 16'd4});
    chk("trade_ask_upd", ask_upd_c - c1, 1);
    chk("trade_upd_qty", last_upd, 16'd6);
    chk("trade_pops", {bid_pop_c - c2, ask_pop_c - c3}, {32'd1, 32'd0});

    // Trade cap: three 1-lot asks, BUY 3 stops after MATCH_LIMIT=2 trades
    clr_tables();
    preload(1'b0, '{8'd10, 16'd50, 16'd1});
    preload(1'b0, '{8'd11, 16'd50, 16'd1});
    preload(1'b0, '{8'd12, 16'd50, 16'd1});
    base = rsp_n; c0 = ask_pop_c; c1 = bid_upd_c;
    send(3'd1, 8'd20, 16'd50, 16'd3);
    wait_idle("cap_idle");
    chk("cap_n", rsp_n - base, 2);
    chk("cap_rsp0", rsp_log[base], {2'd1, 8'hff, 8'd20, 8'd10, 16'd50, 16'd1});
    chk("cap_rsp1", rsp_log[base+1], {2'd1, 8'hff, 8'd20, 8'd11, 16'd50, 16'd1});
    chk("cap_ask_pops", ask_pop_c - c0, 2);
    chk("cap_bid_upd", {bid_upd_c - c1, 16'd0, last_upd}, {32'd2, 16'd0, 16'd1});
    base = rsp_n;
    send(3'd0, 8'd21, 16'd0, 16'd0);
    wait_idle("cap_nop_idle");
    chk("cap_nop_n", rsp_n - base, 1);
    chk("cap_nop_rsp", rsp_log[base], {2'd0, 8'd21, 8'd0, 8'd0, 16'd0, 16'd0});
    chk("cap_nop_nopop", ask_pop_c - c0, 2);

    // Rejects: full table, zero quantity
    clr_tables();
    ask_full = 1'b1;
    base = rsp_n; c0 = ask_ins_c; c1 = bid_ins_c;
    send(3'd2, 8'd30, 16'd70, 16'd5);
    wait_idle("full_idle");
    ask_full = 1'b0;
    chk("full_rsp", rsp_log[base], {2'd2, 8'd30, 8'd0, 8'd0, 16'd0, 16'd0});
    chk("full_noins", ask_ins_c - c0, 0);
    send(3'd1, 8'd31, 16'd80, 16'd0);
    wait_idle("qty0_idle");
    chk("qty0_rsp", rsp_log[base+1], {2'd2, 8'd31, 8'd0, 8'd0, 16'd0, 16'd0});
    chk("qty0_noins", bid_ins_c - c1, 0);

    // Query with bid only, then invalid opcode
    preload(1'b1, '{8'd40, 16'd90, 16'd7});
    base = rsp_n;
    send(3'd3, 8'd41, 16'd0, 16'd0);
    wait_idle("qry_idle");
    chk("qry_rsp", rsp_log[base], {2'd0, 8'd41, 8'd0, 8'd0, 16'd90, 16'd0});
    send(3'd7, 8'd42, 16'd0, 16'd0);
    wait_idle("badop_idle");
    chk("badop_rsp", rsp_log[base+1], {2'd3, 8'd42, 8'd0, 8'd0, 16'd0, 16'd0});

    // Reset while in EXE abandons the pending trade
    clr_tables();
    preload(1'b0, '{8'd50, 16'd100, 16'd10});
    base = rsp_n; c0 = bid_pop_c; c1 = ask_upd_c;
    send(3'd1, 8'd51, 16'd101, 16'd4);
    @(negedge clk);  // WAIT
    @(negedge clk);  // CMP
    @(negedge clk);  // EXE
    rst = 1'b1;
    #1;
    chk("mid_rst_ctl", {56'd0, cmd_rdy, rsp_vld, bid_insert, ask_insert, bid_pop, ask_pop,
                        bid_upd, ask_upd}, 64'd0);
    chk("mid_rst_data", {rsp_sts, rsp_uid, rsp_price, rsp_qty, upd_qty}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_rdy", {rsp_vld, cmd_rdy}, {1'b0, 1'b1});
    chk("mid_rst_notrade", {rsp_n - base, bid_pop_c - c0, ask_upd_c - c1}, 96'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ob_match_engine.md
Name: ob_match_engine

Overview:
- Parametrised second-generation order-book controller. Sits between the command ingress queue and the bid/ask head tables.
- Decodes NOP/BUY/SELL/QRY commands and installs orders into the bid and ask tables.
- Iterates head-of-book matching, at most MATCH_LIMIT trades per command, and emits responses over a ready/valid channel with backpressure.
- New in this generation: configurable widths, a per-command trade cap with continuation, a reported trade price, and a registered compare stage with explicit table-latency handling.

Parameters:
- UID_W, 8, order/command identifier width.
- PRICE_W, 16, price width (unsigned).
- QTY_W, 16, quantity width (unsigned).
- MATCH_LIMIT, 4, maximum trades per command before yielding to the next command (≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cmd_vld  in  1  command valid.
- cmd_opc  in  3  opcode: 0 NOP, 1 BUY, 2 SELL, 3 QRY; other values invalid.
- cmd_uid  in  UID_W  command id.
- cmd_price  in  PRICE_W  limit price.
- cmd_qty  in  QTY_W  quantity.
- cmd_rdy  out  1  command accepted when cmd_vld & cmd_rdy.
- rsp_vld  out  1  response valid.
- rsp_rdy  in  1  response sink ready.
- rsp_sts  out  2  0 OKAY, 1 TRADE, 2 REJECT, 3 BADOP.
- rsp_uid  out  UID_W  originator id; all-ones for TRADE.
- rsp_bid_uid / rsp_ask_uid  out  UID_W  trade parties; QRY leaves them zero.
- rsp_price  out  PRICE_W  trade price, or best bid for QRY.
- rsp_qty  out  QTY_W  trade quantity, or best ask price (low bits) for QRY.
- {bid,ask}_head_vld  in  1  table non-empty.
- {bid,ask}_head_uid / _price / _qty  in  UID_W / PRICE_W / QTY_W  head entry.
- {bid,ask}_full  in  1  table cannot accept an insert.
- {bid,ask}_insert  out  1  insert pulse.
- ins_uid / ins_price / ins_qty  out  shared insert payload.
- {bid,ask}_pop  out  1  pop head.
- {bid,ask}_upd  out  1  overwrite head quantity.
- upd_qty  out  QTY_W  new head quantity.

Behaviour:
- Reset: FSM=IDLE, trade counter 0, command register invalid. All outputs 0, including cmd_rdy.
- cmd_rdy=1 only in IDLE with no held response. The command is registered on acceptance; decode occurs the following cycle (state DEC).
- Response output is a registered skid slot. rsp_* is held stable while rsp_vld & ~rsp_rdy. The FSM never generates a new response while the slot is occupied and not draining.
- DEC, NOP: response OKAY(uid) -> IDLE.
- DEC, invalid opcode: response BADOP -> IDLE.
- DEC, QRY: response OKAY with rsp_price = bid head price (0 if empty) and rsp_qty = ask head price (0 if empty) -> IDLE.
- DEC, BUY/SELL with target table full: response REJECT(uid), no insert -> IDLE.
- DEC, BUY/SELL otherwise: one-cycle insert pulse; if qty==0, REJECT with no insert -> IDLE; else -> WAIT.
- WAIT: one cycle for the table heads to settle -> CMP.
- CMP: registers the compare result and goes to EXE.
  - can = bid_vld & ask_vld & (bid_price >= ask_price).
  - tq = min(bid_qty, ask_qty).
  - rem = |bid_qty - ask_qty|, computed in QTY_W bits, no overflow since operands are unsigned and the larger is subtracted.
- EXE, can=0: -> IDLE (OKAY was already implied by the insert; no response).
- EXE, can=1 and response slot free: emit TRADE with rsp_price = ask head price, rsp_qty = tq.
  - bid_qty > ask_qty: ask_pop, bid_upd with upd_qty = rem.
  - bid_qty < ask_qty: bid_pop, ask_upd.
  - Equal: both pops.
  - Increment trade counter; if counter == MATCH_LIMIT, clear it -> IDLE; else -> WAIT.
- EXE, can=1 and slot busy: stall in EXE with no table side-effects.
- Pop/update and response happen in the same cycle (atomic).
- Trade counter clears on every accepted command.
- Async reset mid-match abandons the match; the tables own their own state.

Optional Feature:
- Macro OB_MATCH_ENGINE_STATS_EN.
- Defined: adds outputs stat_trades (32), stat_volume (32), stat_rejects (16).
  - Saturating counters, cleared by rst.
  - stat_trades +1 and stat_volume +tq per TRADE issued.
  - stat_rejects +1 per REJECT.
- Undefined: no stat ports and no counters.

Decomposition:
- Shared package ob_pkg gains:
  - opcode enum.
  - rsp status enum.
  - fsm_state_t {IDLE, DEC, WAIT, CMP, EXE}.
  - cmp_result_t struct parametrised by the widths through module-local typedefs.
- One sub-module, ob_rsp_skid: a one-entry ready/valid response register with a valid/ready/data interface.

Test Plan:
- rst pulse mid-EXE -> all outputs 0 and cmd_rdy=1 the next cycle after release.
- NOP uid=5 with rsp_rdy=0 for 3 cycles -> rsp_vld held with sts OKAY, uid 5; cmd_rdy=0 until drained.
- Ask head (uid 2, price 100, qty 10); BUY uid 3 price 101 qty 4 -> bid_insert, then TRADE bid 3 ask 2 price 100 qty 4; ask_upd upd_qty=6; bid_pop.
- Three asks of qty 1 at price 50, MATCH_LIMIT=2; BUY qty 3 price 50 -> two TRADEs, then IDLE accepts the next command; the following NOP triggers none.
- SELL with ask_full=1 -> REJECT uid, no ask_insert; BUY qty 0 -> REJECT.
- QRY with bid head 90 and empty ask -> OKAY, rsp_price 90, rsp_qty 0; opcode 7 -> BADOP.
